i2c_slave_byte_ctrl: RTL

//  Byte-level I2C slave engine fed by the bus debounce/condition detector stage.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_shift8.sv | 40 ++++
 rtl/i2c_slave_byte_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding and the ACK/NACK bus levels
// used by both the slave byte engine and the master engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_LOAD  = 3'd5,
    RD_DATA  = 3'd6,
    RD_ACK   = 3'd7
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_shift8.sv
// 8-bit MSB-first shift register with parallel load, a 0..8 bit counter
// and a done flag that is raised once eight bits have been shifted.
module i2c_shift8 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic [7:0] data_o,
  output logic [3:0] cnt_o,
  output logic       done_o
);

  logic [7:0] data_q;
  logic [3:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= 8'h00;
      cnt_q  <= 4'd0;
    end else if (load_i) begin
      data_q <= load_data_i;
      cnt_q  <= 4'd0;
    end else if (clr_i) begin
      cnt_q  <= 4'd0;
    end else if (shift_i && (cnt_q != 4'd8)) begin
      data_q <= {data_q[6:0], bit_i};
      cnt_q  <= cnt_q + 4'd1;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == 4'd8);

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave engine: address match, write receive with ACK/NACK,
// read transmit with optional SCL stretching while read data is unavailable.
module i2c_slave_byte_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter bit STRETCH_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              sta_det,
  input  logic              sto_det,
  input  logic              scl_rising,
  input  logic              scl_falling,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              scl_o,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ack_en,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              addr_hit,
  output logic              rd_mode,
  output logic              nack_det,
  output logic              slv_active
);

  i2c_state_e state_q, state_d;
  logic       sda_q, sda_d, scl_q, scl_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, addr_hit_q, addr_hit_d;
  logic       nack_det_q, nack_det_d, rd_mode_q, rd_mode_d;
  logic       slv_active_q, slv_active_d, tx_ready_q;

  logic       rise, fall, tx_take;
  logic       sh_clr, sh_load, sh_shift, sh_restart, sh_done;
  logic [7:0] sh_data, sh_next, load_byte;
  logic [3:0] sh_cnt;

  // Rising strobe wins if the edge detector ever flags both edges at once.
  assign rise      = scl_rising;
  assign fall      = scl_falling & ~scl_rising;
  assign sh_next   = {sh_data[6:0], sda_i};
  assign tx_take   = tx_valid & tx_ready_q;
  assign load_byte = tx_valid ? tx_data : 8'hFF;
  assign sh_clr    = sh_restart | (state_d != state_q);

  i2c_shift8 u_shift (
    .clk         (clk),
    .rstn        (rstn),
    .clr_i       (sh_clr),
    .load_i      (sh_load),
    .load_data_i (load_byte),
    .shift_i     (sh_shift),
    .bit_i       (sda_i),
    .data_o      (sh_data),
    .cnt_o       (sh_cnt),
    .done_o      (sh_done)
  );

  // NOTE: every always_comb output is defaulted first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    sda_d        = sda_q;
    scl_d        = scl_q;
    rx_data_d    = rx_data_q;
    rd_mode_d    = rd_mode_q;
    slv_active_d = slv_active_q;
    rx_valid_d   = 1'b0;
    addr_hit_d   = 1'b0;
    nack_det_d   = 1'b0;
    sh_shift     = 1'b0;
    sh_load      = 1'b0;
    sh_restart   = 1'b0;

    if (!enable || sto_det) begin
      state_d      = IDLE;
      sda_d        = 1'b1;
      scl_d        = 1'b1;
      slv_active_d = 1'b0;
    end else if (sta_det) begin
      state_d    = ADDR;
      sda_d      = 1'b1;
      scl_d      = 1'b1;
      sh_restart = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (rise) begin
            sh_shift = 1'b1;
            if (sh_cnt == 4'd7) begin
              addr_hit_d   = (sh_next[7:1] == slave_addr);
              slv_active_d = (sh_next[7:1] == slave_addr);
              rd_mode_d    = sh_next[0];
            end
          end else if (fall && sh_done) begin
            // slv_active_q holds the compare result taken on the 8th rise.
            if (slv_active_q) begin
              sda_d   = I2C_ACK;
              state_d = ADDR_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            sda_d = 1'b1;
            if (rd_mode_q) begin
              state_d = RD_LOAD;
              scl_d   = !STRETCH_EN;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (rise) begin
            sh_shift = 1'b1;
            if (sh_cnt == 4'd7) begin
              rx_data_d  = sh_next;
              rx_valid_d = 1'b1;
            end
          end else if (fall && sh_done) begin
            sda_d   = rx_ack_en ? I2C_ACK : I2C_NACK;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (fall) begin
            sda_d = 1'b1;
            if (sda_q == I2C_ACK) begin
              state_d = WR_DATA;
            end else begin
              state_d      = IDLE;
              slv_active_d = 1'b0;
            end
          end
        end
        RD_LOAD: begin
          if (tx_take || !STRETCH_EN) begin
            sh_load = 1'b1;
            sda_d   = load_byte[7];
            scl_d   = 1'b1;
            state_d = RD_DATA;
          end
        end
        RD_DATA: begin
          if (rise) begin
            sh_shift = 1'b1;
          end else if (fall) begin
            if (sh_done) begin
              sda_d   = 1'b1;
              state_d = RD_ACK;
            end else begin
              sda_d = sh_data[7];
            end
          end
        end
        RD_ACK: begin
          if (rise && (sda_i == I2C_NACK)) begin
            nack_det_d   = 1'b1;
            slv_active_d = 1'b0;
            state_d      = IDLE;
          end else if (fall) begin
            state_d = RD_LOAD;
            scl_d   = !STRETCH_EN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      sda_q        <= 1'b1;
      scl_q        <= 1'b1;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      addr_hit_q   <= 1'b0;
      nack_det_q   <= 1'b0;
      rd_mode_q    <= 1'b0;
      slv_active_q <= 1'b0;
      tx_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sda_q        <= sda_d;
      scl_q        <= scl_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_hit_q   <= addr_hit_d;
      nack_det_q   <= nack_det_d;
      rd_mode_q    <= rd_mode_d;
      slv_active_q <= slv_active_d;
      tx_ready_q   <= (state_d == RD_LOAD);
    end
  end

  assign sda_o      = sda_q;
  assign scl_o      = scl_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_hit   = addr_hit_q;
  assign nack_det   = nack_det_q;
  assign rd_mode    = rd_mode_q;
  assign slv_active = slv_active_q;
  assign tx_ready   = tx_ready_q;

endmodule
